// File: rtl/tt_sweep_capture.sv
// Truth-table sweeper: walks a 7-input combinational function through all 128 vectors
// and captures its 1-bit result into a 128-bit table with popcount and signature match.
module tt_sweep_capture #(
    parameter int SETTLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         abort,
    input  logic [127:0] expected,
    input  logic         dut_out,
    output logic [6:0]   dut_x,
    output logic         busy,
    output logic         done,
    output logic [127:0] truth_table,
    output logic [7:0]   ones_count,
    output logic         match
);

    // state | meaning
    // IDLE  | waiting for start, outputs hold last sweep result
    // RUN   | vector applied, wait counter settling toward SETTLE
    // DONE  | one-cycle done pulse, then back to IDLE
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [3:0] SETTLE_C = 4'(SETTLE);

    state_t       state, state_nxt;
    logic [3:0]   cnt;
    logic         go;
    logic         sample;
    logic [127:0] tt_upd;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        go        = 1'b0;
        sample    = 1'b0;
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    state_nxt = RUN;
                    go        = 1'b1;
                end
            end
            RUN: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (cnt == SETTLE_C) begin
                    sample = 1'b1;
                    if (dut_x == 7'd127) state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Table with only the current vector's bit replaced; also feeds the final compare.
    always_comb begin
        tt_upd        = truth_table;
        tt_upd[dut_x] = dut_out;
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dut_x       <= '0;
            cnt         <= '0;
            truth_table <= '0;
            ones_count  <= '0;
            match       <= 1'b0;
        end else if (go) begin
            dut_x       <= '0;
            cnt         <= '0;
            truth_table <= '0;
            ones_count  <= '0;
            match       <= 1'b0;
        end else if (state == RUN) begin
            if (abort) begin
                cnt   <= '0;
                match <= 1'b0;
            end else if (sample) begin
                truth_table <= tt_upd;
                ones_count  <= ones_count + {7'd0, dut_out};
                cnt         <= '0;
                if (dut_x != 7'd127) dut_x <= dut_x + 7'd1;
                else                 match <= (tt_upd == expected);
            end else begin
                cnt <= cnt + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_tt_sweep_capture.sv
// Bench for tt_sweep_capture: directed sweeps on two instances (SETTLE=1 and SETTLE=2)
// with stub functions, per-cycle dut_x/busy/done probing and a result scoreboard.
module tb_tt_sweep_capture;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start1 = 1'b0, abort1 = 1'b0, out1;
    logic         start2 = 1'b0, abort2 = 1'b0, out2;
    logic [127:0] exp1 = '0, exp2 = '0;
    logic [6:0]   x1, x2;
    logic         busy1, done1, match1, busy2, done2, match2;
    logic [127:0] tt1, tt2;
    logic [7:0]   ones1, ones2;
    int           mode1 = 0, mode2 = 0;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [127:0] tt;
        logic [7:0]   ones;
        logic         m;
    } sb_t;
    sb_t q[$];

    always #5 clk = ~clk;

    function automatic logic stub(input int mode, input logic [6:0] x);
        case (mode)
            0:       return x[6];
            1:       return &x;
            2:       return x[0] ^ x[1];
            default: return 1'b1;
        endcase
    endfunction

    assign out1 = stub(mode1, x1);
    assign out2 = stub(mode2, x2);

    tt_sweep_capture #(.SETTLE(1)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1), .expected(exp1),
        .dut_out(out1), .dut_x(x1), .busy(busy1), .done(done1),
        .truth_table(tt1), .ones_count(ones1), .match(match1)
    );

    tt_sweep_capture #(.SETTLE(2)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort2), .expected(exp2),
        .dut_out(out2), .dut_x(x2), .busy(busy2), .done(done2),
        .truth_table(tt2), .ones_count(ones2), .match(match2)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0]   gx(input int u);    return (u == 1) ? x1 : x2;       endfunction
    function automatic logic         gbusy(input int u); return (u == 1) ? busy1 : busy2; endfunction
    function automatic logic         gdone(input int u); return (u == 1) ? done1 : done2; endfunction
    function automatic logic         gmatch(input int u);return (u == 1) ? match1 : match2; endfunction
    function automatic logic [127:0] gtt(input int u);   return (u == 1) ? tt1 : tt2;     endfunction
    function automatic logic [7:0]   gones(input int u); return (u == 1) ? ones1 : ones2; endfunction

    task automatic set_start(input int u, input logic v);
        if (u == 1) start1 = v; else start2 = v;
    endtask

    task automatic set_abort(input int u, input logic v);
        if (u == 1) abort1 = v; else abort2 = v;
    endtask

    task automatic check_all_zero(input string tag, input int u);
        check({tag, "_tt"},    gtt(u),   '0);
        check({tag, "_ones"},  128'(gones(u)), '0);
        check({tag, "_x"},     128'(gx(u)),    '0);
        check({tag, "_busy"},  128'(gbusy(u)), '0);
        check({tag, "_done"},  128'(gdone(u)), '0);
        check({tag, "_match"}, 128'(gmatch(u)), '0);
    endtask

    // Caller is just after a falling edge. abort_k / noise_k are cycle indices after the
    // start edge (-1 = unused); reset_vec asserts rst_n on the first cycle of that vector.
    task automatic run_sweep(input int u, input int mode, input int s, input logic [127:0] sig,
                             input int abort_k, input int noise_k, input int reset_vec);
        int           len;
        int           ex;
        int           nsamp;
        sb_t          e;
        sb_t          got;
        logic [127:0] part;
        len    = 128 * (s + 1);
        e.tt   = '0;
        e.ones = '0;
        for (int v = 0; v < 128; v++) begin
            e.tt[v] = stub(mode, 7'(v));
            e.ones  = e.ones + 8'(e.tt[v]);
        end
        e.m = (e.tt == sig);
        q.push_back(e);
        set_start(u, 1'b1);
        @(negedge clk);
        for (int k = 0; k <= len; k++) begin
            ex = k / (s + 1);
            if (ex > 127) ex = 127;
            set_start(u, k == noise_k);
            check("x_walk", 128'(gx(u)), 128'(ex));
            check("busy",   128'(gbusy(u)), 128'(k < len));
            check("done",   128'(gdone(u)), 128'(k == len));
            if (k == len) begin
                got = q.pop_front();
                check("sweep_tt",    gtt(u),           got.tt);
                check("sweep_ones",  128'(gones(u)),   128'(got.ones));
                check("sweep_match", 128'(gmatch(u)),  128'(got.m));
            end
            if (k == abort_k) begin
                set_abort(u, 1'b1);
                @(negedge clk);
                set_abort(u, 1'b0);
                set_start(u, 1'b0);
                void'(q.pop_front());
                nsamp = k / (s + 1);
                part  = '0;
                for (int v = 0; v < nsamp; v++) part[v] = stub(mode, 7'(v));
                check("abort_busy",  128'(gbusy(u)),  '0);
                check("abort_match", 128'(gmatch(u)), '0);
                check("abort_x",     128'(gx(u)),     128'(nsamp));
                check("abort_tt",    gtt(u),          part);
                check("abort_ones",  128'(gones(u)),  128'(nsamp));
                for (int j = 0; j < 6 * (s + 1); j++) begin
                    @(negedge clk);
                    check("abort_nodone", 128'(gdone(u)), '0);
                end
                return;
            end
            if (reset_vec >= 0 && ex == reset_vec && (k % (s + 1)) == 0) begin
                rst_n = 1'b0;
                set_start(u, 1'b0);
                #1;
                check_all_zero("midreset", u);
                void'(q.pop_front());
                @(negedge clk);
                check("midreset_nodone", 128'(gdone(u)), '0);
                rst_n = 1'b1;
                @(negedge clk);
                return;
            end
            @(negedge clk);
        end
        set_start(u, 1'b0);
        check("post_idle_busy", 128'(gbusy(u)), '0);
        check("post_idle_done", 128'(gdone(u)), '0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_all_zero("reset_u1", 1);
        check_all_zero("reset_u2", 2);
        rst_n = 1'b1;
        @(negedge clk);

        // Top-bit stub, start pulse during the sweep is ignored.
        mode1 = 0;
        exp1  = {{64{1'b1}}, {64{1'b0}}};
        run_sweep(1, 0, 1, exp1, -1, 10, -1);

        // AND stub on SETTLE=2; signature mismatch.
        mode2 = 1;
        exp2  = '0;
        run_sweep(2, 1, 2, exp2, -1, -1, -1);

        // XOR stub; start during the done cycle is ignored, then immediate restart.
        mode1 = 2;
        exp1  = {32{4'h6}};
        run_sweep(1, 2, 1, exp1, -1, 256, -1);
        run_sweep(1, 2, 1, exp1, -1, -1, -1);

        // start and abort together in IDLE: stays idle.
        start1 = 1'b1;
        abort1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        abort1 = 1'b0;
        check("start_abort_idle_busy", 128'(busy1), '0);
        check("start_abort_idle_x",    128'(x1),    128'(127));

        // Constant-1 stub aborted on the sampling edge of vector 40.
        mode1 = 3;
        exp1  = '1;
        run_sweep(1, 3, 1, exp1, 81, 20, -1);

        // Reset at vector 90, then a clean full sweep.
        run_sweep(1, 3, 1, exp1, -1, -1, 90);
        run_sweep(1, 3, 1, exp1, -1, -1, -1);
        check("allones_count", 128'(ones1), 128'(128));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tt_sweep_capture.md
# tt_sweep_capture

Sequential truth-table sweeper placed directly upstream and downstream of a 7-input combinational classification function. It drives all 128 input vectors onto the function's inputs in ascending order and samples the 1-bit result for each vector. It assembles the results into a 128-bit truth table whose hex form matches the team's signature naming, with MSB = vector 127. It also reports the population count and whether the table equals an expected signature.

## Interface
- SETTLE, default 1: cycles each vector is held before its result is sampled. Legal range 1..15.
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle request to begin a sweep. Honoured only in IDLE.
- abort  in  1  synchronous abort; returns to IDLE without asserting done.
- expected  in  128  reference signature; sampled at the same edge that sets done.
- dut_out  in  1  result of the combinational function for the current dut_x.
- dut_x  out  7  registered vector for the function; dut_x[0] = x0 … dut_x[6] = x6.
- busy  out  1  high from the edge after an accepted start until the edge that sets done.
- done  out  1  one-cycle pulse when the sweep completes.
- truth_table  out  128  bit v = dut_out sampled while dut_x == v.
- ones_count  out  8  number of 1s in truth_table, range 0..128.
- match  out  1  (truth_table == expected); valid from done, held until the next start.

## Operation
- States:
  - IDLE: busy=0, outputs hold their last values.
  - RUN: vector is applied and settling, wait counter active.
  - DONE: done=1 for one cycle, then unconditional return to IDLE.
- IDLE→RUN on start. At the accepting edge:
  - dut_x←0, wait counter←0.
  - truth_table←0, ones_count←0, match←0, busy←1.
- In RUN, the wait counter increments each cycle. When the counter reaches SETTLE, the edge does the following:
  - Samples dut_out into truth_table[dut_x].
  - Increments ones_count if dut_out=1.
  - Clears the counter.
  - Advances dut_x by 1.
- After vector 127 is sampled, the transition is RUN→DONE. The same edge:
  - Sets match, using the final table including bit 127.
  - Clears busy.
  - Leaves dut_x at 127; it is not wrapped to 0.
- In RUN, the update for vector v writes only bit v; all other bits are untouched.
- ones_count is a running count. It never exceeds 128, so there is no overflow.
- start while busy or in DONE: ignored. No restart and no effect on the table.
- abort in RUN: next state IDLE, busy←0, done stays 0.
  - truth_table, ones_count and dut_x keep their partial values.
  - match←0.
  - abort takes priority over a sample on the same edge; that sample is discarded.
- abort in IDLE or DONE has no effect. The done pulse still completes.
- start and abort both high in IDLE: abort wins and the block stays IDLE.

## Timing
- Reset (asynchronous, immediate):
  - State IDLE.
  - dut_x=0, busy=0, done=0, match=0.
  - truth_table=0, ones_count=0, wait counter=0.
- Reset mid-sweep: all state returns to reset values at once. No done is produced.
- Each vector is held for SETTLE+1 cycles. dut_out is sampled at the last edge of that window.
- Start accepted at edge E0. The sample of vector v occurs at edge E0+(v+1)(SETTLE+1).
- done is high in the cycle following edge E0+128(SETTLE+1).
  - SETTLE=1: 256 cycles after start.
  - SETTLE=2: 384 cycles after start.
- Next start is accepted no earlier than the cycle after done (first IDLE cycle).
- dut_x changes only on sampling edges or on the start edge. It is glitch-free from the register.

## Test plan
- Stub dut_out = dut_x[6], SETTLE=1, start pulse → done 256 cycles later; truth_table = 0xFFFFFFFFFFFFFFFF0000000000000000; ones_count=64; match=1 with expected equal to that value.
- Stub dut_out = AND of all dut_x, SETTLE=2 → done exactly 384 cycles after start; truth_table = 0x8000…0 (bit 127 only); ones_count=1; expected=0 → match=0.
- Stub dut_out = dut_x[0] XOR dut_x[1] → truth_table = 0x66666666666666666666666666666666; ones_count=64. Then start again immediately after done → second sweep gives an identical result.
- Mid-sweep abort at vector 40 → busy falls, done never pulses, match=0, bits 40..127 remain 0. Start pulses asserted during the sweep are shown to be ignored.
- rst_n asserted low at vector 90 of a constant-1 stub → all outputs zero immediately. After release and a new start, a full sweep gives all-ones, ones_count=128.
- Probe dut_x each cycle → it increments exactly once per SETTLE+1 cycles, 0..127, never skipping or repeating, and holds at 127 after done.
